// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//
// Multi-cycle adder for NIBBLES*4-bit operands. The operands go through one
// 4-bit ripple carry adder, one nibble per clock, least significant nibble
// first. The carry is held in a register from one nibble to the next.
//
// START/READY handshake on the operand side. On the result side there is a
// one-cycle DONE pulse, and the result stays on Z/C_out/OVF after it.
//
// Optional feature:
//   NIBBLE_SERIAL_SUB_EN : adds input SUB. SUB=1 computes X - Y by adding ~Y
//                          with a carry-in of 1. C_out=1 then means "no borrow".
//
// Ports:
//   CLK    in   1  rising-edge clock
//   RST    in   1  asynchronous, active-high reset
//   START  in   1  request; accepted only while READY=1
//   READY  out  1  high in IDLE only
//   X      in   W  operand A, sampled on accepted START
//   Y      in   W  operand B, sampled on accepted START
//   C_in   in   1  carry into nibble 0, sampled on accepted START
//   SUB    in   1  (NIBBLE_SERIAL_SUB_EN only) subtract request
//   Z      out  W  sum, held until the next operation completes
//   C_out  out  1  carry out of the top nibble
//   OVF    out  1  two's-complement overflow
//   BUSY   out  1  high in RUN and DONE
//   DONE   out  1  one-cycle pulse when Z/C_out/OVF are newly valid
// -----------------------------------------------------------------------------

module ripple_addr_4_bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);
  always_comb begin
    // NOTE: 'c' is a scratch value inside this combinational block. Blocking
    // '=' makes each bit see the carry from the bit below it in the same pass.
    logic c;
    c = c_in;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    c_out = c;
  end
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START,
  output logic                   READY,
  input  logic [4*NIBBLES-1:0]   X,
  input  logic [4*NIBBLES-1:0]   Y,
  input  logic                   C_in,
`ifdef NIBBLE_SERIAL_SUB_EN
  input  logic                   SUB,
`endif
  output logic [4*NIBBLES-1:0]   Z,
  output logic                   C_out,
  output logic                   OVF,
  output logic                   BUSY,
  output logic                   DONE
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  xr, yr, acc;
  logic          cr, sx, sy;
  logic [CW-1:0] cnt;
  logic [3:0]    add_s;
  logic          add_c;

  // The only adder in the block. It always works on the low nibble of the
  // shift registers.
  ripple_addr_4_bit u_add (
    .a     (xr[3:0]),
    .b     (yr[3:0]),
    .c_in  (cr),
    .s     (add_s),
    .c_out (add_c)
  );

  // NOTE: every registered signal uses non-blocking '<='. All flops then
  // update together at the edge, whatever order the statements are in.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first. A path that
    // forgets to assign one then cannot infer a latch.
    state_nxt = state;
    READY     = 1'b0;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    unique case (state)
      S_IDLE: begin
        READY = 1'b1;
        if (START) state_nxt = S_RUN;
      end
      S_RUN: begin
        BUSY = 1'b1;
        if (cnt == LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        BUSY      = 1'b1;
        DONE      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      xr    <= '0;
      yr    <= '0;
      acc   <= '0;
      cr    <= 1'b0;
      sx    <= 1'b0;
      sy    <= 1'b0;
      cnt   <= '0;
      Z     <= '0;
      C_out <= 1'b0;
      OVF   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (START) begin
            xr  <= X;
            sx  <= X[W-1];
            cnt <= '0;
`ifdef NIBBLE_SERIAL_SUB_EN
            if (SUB) begin
              yr <= ~Y;
              cr <= 1'b1;
              sy <= ~Y[W-1];
            end else begin
              yr <= Y;
              cr <= C_in;
              sy <= Y[W-1];
            end
`else
            yr <= Y;
            cr <= C_in;
            sy <= Y[W-1];
`endif
          end
        end
        S_RUN: begin
          xr  <= {4'b0000, xr[W-1:4]};
          yr  <= {4'b0000, yr[W-1:4]};
          acc <= {add_s, acc[W-1:4]};
          cr  <= add_c;
          cnt <= cnt + 1'b1;
          // The visible outputs load only on the final nibble. Z never
          // shows a partial sum, and it keeps its value until the next
          // operation finishes.
          if (cnt == LAST) begin
            Z     <= {add_s, acc[W-1:4]};
            C_out <= add_c;
            OVF   <= (sx == sy) && (add_s[3] != sx);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
//
// Self-checking bench for nibble_serial_adder with NIBBLES=4 (16-bit operands).
// The model works at the transaction level. It computes each result with plain
// wide arithmetic when START is accepted. It then follows how many cycles have
// passed since acceptance, to predict READY/BUSY/DONE and when the held result
// changes. Directed operations add literal expectations that pin the model.
// Define NIBBLE_SERIAL_SUB_EN to exercise subtraction too.
// -----------------------------------------------------------------------------

module tb_nibble_serial_adder;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         START;
  logic         READY;
  logic [W-1:0] X, Y;
  logic         C_in;
`ifdef NIBBLE_SERIAL_SUB_EN
  logic         SUB;
`endif
  logic [W-1:0] Z;
  logic         C_out, OVF, BUSY, DONE;

  int n_checks = 0;
  int n_pass   = 0;

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .READY (READY),
    .X     (X),
    .Y     (Y),
    .C_in  (C_in),
`ifdef NIBBLE_SERIAL_SUB_EN
    .SUB   (SUB),
`endif
    .Z     (Z),
    .C_out (C_out),
    .OVF   (OVF),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  int           k;          // 0 = idle, otherwise edges since acceptance
  logic [W-1:0] m_z, p_z;
  logic         m_c, m_o, p_c, p_o;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      k   = 0;
      m_z = '0;
      m_c = 1'b0;
      m_o = 1'b0;
    end else if (k == 0) begin
      if (START) begin
        logic [W:0]   full;
        logic [W-1:0] yy;
        logic         cin;
        yy  = Y;
        cin = C_in;
`ifdef NIBBLE_SERIAL_SUB_EN
        if (SUB) begin
          yy  = ~Y;
          cin = 1'b1;
        end
`endif
        full = {1'b0, X} + {1'b0, yy} + {{W{1'b0}}, cin};
        p_z  = full[W-1:0];
        p_c  = full[W];
        p_o  = (X[W-1] == yy[W-1]) && (full[W-1] != X[W-1]);
        k    = 1;
      end
    end else begin
      k++;
      if (k == NIBBLES + 1) begin
        m_z = p_z;
        m_c = p_c;
        m_o = p_o;
      end else if (k == NIBBLES + 2) begin
        k = 0;
      end
    end
    #1;
    check("z",     Z,     m_z);
    check("c_out", C_out, m_c);
    check("ovf",   OVF,   m_o);
    check("ready", READY, k == 0);
    check("busy",  BUSY,  k != 0);
    check("done",  DONE,  k == NIBBLES + 1);
  end

  // ---------------- directed helpers ----------------
  task automatic wait_ready();
    int n = 0;
    while (!READY && n < 20) begin @(negedge CLK); n++; end
    check("ready_timeout", READY, 1'b1);
  endtask

  task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic cin, input logic sub,
                        input logic [W-1:0] ez, input logic ec, input logic eo);
    int lat = 0;
    @(negedge CLK);
    wait_ready();
    X = x; Y = y; C_in = cin; START = 1'b1;
`ifdef NIBBLE_SERIAL_SUB_EN
    SUB = sub;
`else
    if (sub) $display("note: %s requests SUB without NIBBLE_SERIAL_SUB_EN", name);
`endif
    @(negedge CLK);
    START = 1'b0;
    while (!DONE && lat < 40) begin @(negedge CLK); lat++; end
    check({name, "_latency"}, lat, NIBBLES);
    check({name, "_z"},       Z,     ez);
    check({name, "_c"},       C_out, ec);
    check({name, "_ovf"},     OVF,   eo);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dones;
    START = 1'b0; X = '0; Y = '0; C_in = 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
    SUB = 1'b0;
`endif
    #2 RST = 1'b1;
    #1;
    check("rst_z", Z, 0);
    check("rst_ready", READY, 1);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;

    run_op("ffff_plus_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("1234_4321_c", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    repeat (4) @(negedge CLK);
    check("hold_z", Z, 16'h5556);
    run_op("7fff_plus_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("8000_8000",   16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // START during RUN is ignored; the original operands win.
    @(negedge CLK);
    wait_ready();
    X = 16'h1111; Y = 16'h2222; C_in = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    X = 16'hAAAA; Y = 16'h5555; START = 1'b1;
    check("ready_in_run", READY, 1'b0);
    @(negedge CLK);
    START = 1'b0;
    begin
      int n = 0;
      while (!DONE && n < 20) begin @(negedge CLK); n++; end
    end
    check("ignored_start_z", Z, 16'h3333);
    check("ignored_start_c", C_out, 1'b0);

    // Reset two cycles into RUN.
    @(negedge CLK);
    wait_ready();
    X = 16'h0F0F; Y = 16'h0101; C_in = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK); @(negedge CLK);
    RST = 1'b1;
    #1;
    check("midrun_rst_z", Z, 0);
    check("midrun_rst_c", C_out, 0);
    check("midrun_rst_busy", BUSY, 0);
    check("midrun_rst_ready", READY, 1);
    @(negedge CLK);
    RST = 1'b0;
    dones = 0;
    repeat (8) begin @(negedge CLK); if (DONE) dones++; end
    check("no_done_after_rst", dones, 0);
    run_op("after_rst", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);

`ifdef NIBBLE_SERIAL_SUB_EN
    run_op("sub_5_7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_7_5", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
`endif

    // START held high: one acceptance per NIBBLES+2 cycles.
    @(negedge CLK);
    wait_ready();
    START = 1'b1;
    dones = 0;
    repeat (3 * (NIBBLES + 2)) begin
      @(negedge CLK);
      if (DONE) dones++;
      X = W'($urandom); Y = W'($urandom); C_in = 1'($urandom);
    end
    START = 1'b0;
    check("held_start_dones", dones, 3);

    // Random traffic; the model checks every cycle.
    repeat (600) begin
      @(negedge CLK);
      START = ($urandom % 3) == 0;
      X     = W'($urandom);
      Y     = W'($urandom);
      C_in  = 1'($urandom);
`ifdef NIBBLE_SERIAL_SUB_EN
      SUB   = 1'($urandom);
`endif
    end
    START = 1'b0;
    repeat (NIBBLES + 3) @(negedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
